// File: rtl/dist_argmin_32_if.sv
// rtl/dist_argmin_32_if.sv - handshake bundle for dist_argmin_32; out_dist exists only when ARGMIN_DIST_OUT_EN is defined
interface dist_argmin_32_if #(
  parameter int W      = 6,
  parameter int WC     = 32,
  parameter int NBEATS = 4,
  parameter int NPROTO = 8
);
  localparam int IW = (NPROTO > 1) ? $clog2(NPROTO) : 1;
`ifdef ARGMIN_DIST_OUT_EN
  localparam int SW = W + $clog2(WC);
  localparam int DW = SW + $clog2(NBEATS);
`endif

  logic              in_valid;
  logic              in_ready;
  logic [W*WC-1:0]   in_diff;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_idx;
`ifdef ARGMIN_DIST_OUT_EN
  logic [DW-1:0]     out_dist;
`endif

  // Upstream beat source and downstream result sink, seen from outside the block
  modport master (
    output in_valid, in_diff, out_ready,
    input  in_ready, out_valid, out_idx
`ifdef ARGMIN_DIST_OUT_EN
    , input out_dist
`endif
  );

  // The argmin block itself
  modport slave (
    input  in_valid, in_diff, out_ready,
    output in_ready, out_valid, out_idx
`ifdef ARGMIN_DIST_OUT_EN
    , output out_dist
`endif
  );
endinterface

// File: rtl/dist_argmin_32.sv
// rtl/dist_argmin_32.sv - SAD accumulate and argmin over prototypes; ARGMIN_DIST_OUT_EN adds out_dist
module dist_argmin_32 #(
  parameter int W      = 6,
  parameter int WC     = 32,
  parameter int NBEATS = 4,
  parameter int NPROTO = 8
) (
  input  logic           clk,
  input  logic           rst,
  dist_argmin_32_if.slave bus
);
  localparam int SW = W + $clog2(WC);
  localparam int DW = SW + $clog2(NBEATS);
  localparam int IW = (NPROTO > 1) ? $clog2(NPROTO) : 1;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [IW-1:0]   out_idx_q;
`ifdef ARGMIN_DIST_OUT_EN
  logic [DW-1:0]   out_dist_q;
`endif

  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]   proto_cnt_q, proto_cnt_d;

  logic [SW-1:0]   sum_d;
  logic            s1_valid_q;
  logic [SW-1:0]   s1_sum_q;
  logic            s1_last_q;
  logic [IW-1:0]   s1_tag_q;

  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   min_dist_q, min_dist_d;
  logic [IW-1:0]   min_idx_q, min_idx_d;
  logic [DW-1:0]   cand;
  logic            done_q, done_d;

  logic            accept;
  logic            last_beat;
  logic            last_proto;
  logic            final_beat;
  logic            handoff;

  // in_ready is forced low while rst is asserted so no beat is taken during reset
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
`ifdef ARGMIN_DIST_OUT_EN
  assign bus.out_dist  = out_dist_q;
`endif

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_beat  = (beat_cnt_q == BW'(NBEATS - 1));
  assign last_proto = (proto_cnt_q == IW'(NPROTO - 1));
  assign final_beat = last_beat & last_proto;
  assign handoff    = (state_q == HOLD) & bus.out_ready;

  // Sum of absolute lane differences; the magnitude of the most negative
  // lane value still fits in W unsigned bits, so no saturation is required
  always_comb begin
    logic [W-1:0] lane;
    logic [W-1:0] mag;
    lane  = '0;
    mag   = '0;
    sum_d = '0;
    for (int k = 0; k < WC; k++) begin
      lane  = bus.in_diff[W*k +: W];
      mag   = lane[W-1] ? (W'(0) - lane) : lane;
      sum_d = sum_d + SW'(mag);
    end
  end

  // Beat/prototype position; only accepted beats advance it, handoff restarts the query
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    proto_cnt_d = proto_cnt_q;
    if (handoff) begin
      beat_cnt_d  = '0;
      proto_cnt_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt_d  = '0;
        proto_cnt_d = last_proto ? '0 : proto_cnt_q + IW'(1);
      end else begin
        beat_cnt_d  = beat_cnt_q + BW'(1);
      end
    end
  end

  // Position counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      proto_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      proto_cnt_q <= proto_cnt_d;
    end
  end

  // Stage 1: register the beat sum together with its last-beat and prototype tags
  always_ff @(posedge clk) begin
    if (rst || handoff) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_sum_q  <= sum_d;
        s1_last_q <= last_beat;
        s1_tag_q  <= proto_cnt_q;
      end
    end
  end

  // Stage 2 next state: accumulate, and on a prototype's last beat compare
  // strictly so the earliest prototype keeps a tied minimum
  always_comb begin
    cand       = acc_q + DW'(s1_sum_q);
    acc_d      = acc_q;
    min_dist_d = min_dist_q;
    min_idx_d  = min_idx_q;
    done_d     = 1'b0;
    if (handoff) begin
      acc_d      = '0;
      min_dist_d = '1;
      min_idx_d  = '0;
    end else if (s1_valid_q) begin
      if (s1_last_q) begin
        acc_d = '0;
        if (cand < min_dist_q) begin
          min_dist_d = cand;
          min_idx_d  = s1_tag_q;
        end
        done_d = (s1_tag_q == IW'(NPROTO - 1));
      end else begin
        acc_d = cand;
      end
    end
  end

  // Stage 2 registers; done_q pulses once the final prototype has been compared
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      min_dist_q <= '1;
      min_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      min_dist_q <= min_dist_d;
      min_idx_q  <= min_idx_d;
      done_q     <= done_d;
    end
  end

  // Query control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
`ifdef ARGMIN_DIST_OUT_EN
      out_dist_q  <= '0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (accept && final_beat) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (done_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_idx_q   <= min_idx_q;
`ifdef ARGMIN_DIST_OUT_EN
            out_dist_q  <= min_dist_q;
`endif
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= RUN;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/dist_argmin_32.md
# dist_argmin_32

Downstream stage of the 32-lane 6-bit subtractor in NE_rpu. It consumes one registered difference vector per beat, computes the per-beat sum of absolute differences, and accumulates the sums over NBEATS beats into one prototype distance. Across NPROTO prototypes it tracks the minimum distance and its prototype index. At the end of each query it presents the index, and optionally the distance, on a valid/ready output.

## Interface
- W, 6: bits per lane, two's complement difference
- Wc, 32: lanes per beat
- NBEATS, 4: beats per prototype
- NPROTO, 8: prototypes per query
- SW (derived), W+clog2(Wc) = 11: per-beat sum width
- DW (derived), SW+clog2(NBEATS) = 13: distance width
- IW (derived), clog2(NPROTO) = 3: index width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_diff valid
- in_ready  out  1  block accepts a beat
- in_diff  in  W*Wc  lane k = in_diff[W*k+W-1:W*k], signed
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_idx  out  IW  index of the minimum-distance prototype
- out_dist  out  DW  minimum distance (only when ARGMIN_DIST_OUT_EN is defined)

## Operation
- A beat is accepted on any edge where in_valid & in_ready.
- Two counters track position: beat_cnt (0..NBEATS-1) and proto_cnt (0..NPROTO-1). Both advance only on accepted beats.
  - beat_cnt wraps to 0 after NBEATS-1, and proto_cnt increments at that wrap.
- Stage 1 (registered): s = sum over k of |lane_k|, width SW. |-2^(W-1)| = 2^(W-1) exactly; no saturation is needed.
- Stage 1 carries a valid bit, a last_beat tag, and the proto index tag with the data.
- Stage 2: acc <= acc + s.
  - On a last_beat: cand = acc + s; if cand < min_dist then min_dist <= cand and min_idx <= tag; acc <= 0.
  - The compare is strict less-than, so on a tie the lowest index wins.
  - min_dist is initialised to all-ones at query start.
- FSM states:
  - RUN: in_ready = 1. Accepting the final beat (proto NPROTO-1, beat NBEATS-1) moves to DRAIN.
  - DRAIN: in_ready = 0. Stays until stage 2 has processed the final beat, then moves to HOLD.
  - HOLD: out_valid = 1 and the outputs are stable. out_valid & out_ready moves to RUN; counters, acc and min_dist are re-initialised on that edge.
- Arithmetic is unsigned after abs. DW cannot overflow: the maximum is NBEATS*Wc*2^(W-1) = 4096.
- in_diff is ignored whenever in_ready = 0. Beats may arrive with gaps; bubbles do not advance the counters.

## Timing
- Reset values: in_ready = 0 during rst and 1 on the first cycle after rst deasserts; out_valid = 0; out_idx = 0; out_dist = 0; state = RUN; all counters, acc and pipeline valids cleared.
- Latency: out_valid rises after the 2nd rising edge following the edge that accepted the final beat.
- in_ready is low from the edge that accepted the final beat through the handoff edge. It returns high in the cycle after out_valid & out_ready.
- If out_ready is already high when out_valid rises, the result transfers on the next edge, and out_valid is high for exactly one cycle.
- rst mid-query or mid-HOLD discards all partial state and pipeline contents on that edge; no output is produced for the aborted query.
- rst dominates every other event in the same cycle.

## Configuration
- ARGMIN_DIST_OUT_EN defined: the out_dist port exists and carries min_dist registered with out_idx; it is 0 after reset.
- ARGMIN_DIST_OUT_EN undefined: the out_dist port is omitted. min_dist is still kept internally for the compare, and out_idx behaviour is identical.

## Test plan
- All 32 queries' beats zero (8 protos × 4 beats, in_valid held high) -> out_idx=0, out_dist=0, out_valid 2 edges after the 32nd beat.
- Proto 5 all lanes -1, all other protos all lanes +2 -> out_idx=5, out_dist=128 (the other protos give 256).
- Proto 0 all lanes -32 (4096); protos 2 and 6 each with one lane +25 per beat (100); the rest +1 per lane (128) -> out_idx=2, out_dist=100. This covers the tie rule and the extreme negative value.
- out_ready held low for 10 cycles in HOLD -> out_valid stays 1, in_ready stays 0, outputs stable; raising out_ready gives one transfer, then in_ready=1 on the next cycle.
- Random in_valid gaps (roughly 50% duty) with the second stimulus -> same out_idx=5 / 128; no beat is lost or duplicated.
- rst pulsed after 10 accepted beats, then a fresh second-stimulus query -> no output for the aborted query; result out_idx=5, out_dist=128.
